// File: rtl/mips_cpu_bus_master.sv
// Load/store bus initiator: turns one CPU load/store request into a single
// word-aligned Avalon-style transfer and returns extended load data.
module mips_cpu_bus_master #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cpu_req,
    input  logic [5:0]        cpu_opcode,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic              cpu_busy,
    output logic              cpu_done,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_err,
    output logic [ADDR_W-1:0] address,
    output logic              read,
    output logic              write,
    output logic [3:0]        byteenable,
    output logic [31:0]       writedata,
    input  logic              waitrequest,
    input  logic [31:0]       readdata
);

    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SW  = 6'b101011;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {IDLE, REQ, RDATA} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] address_q, address_d;
    logic              read_q, read_d;
    logic              write_q, write_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [5:0]        op_q, op_d;
    logic [1:0]        lane_q, lane_d;

    logic       supported;
    logic       isStore;
    logic [1:0] opSize;
    logic       misaligned;
    logic       accept;
    logic       reject;
    logic [7:0]  loadByte;
    logic [15:0] loadHalf;
    logic [31:0] loadResult;

    always_comb begin
        supported = 1'b1;
        isStore   = 1'b0;
        opSize    = SZ_BYTE;
        case (cpu_opcode)
            OP_LB, OP_LBU: opSize = SZ_BYTE;
            OP_LH, OP_LHU: opSize = SZ_HALF;
            OP_LW:         opSize = SZ_WORD;
            OP_SB: begin isStore = 1'b1; opSize = SZ_BYTE; end
            OP_SH: begin isStore = 1'b1; opSize = SZ_HALF; end
            OP_SW: begin isStore = 1'b1; opSize = SZ_WORD; end
            default:       supported = 1'b0;
        endcase
    end

    assign misaligned = ((opSize == SZ_HALF) && cpu_addr[0]) ||
                        ((opSize == SZ_WORD) && (cpu_addr[1:0] != 2'b00));
    assign accept     = cpu_req && supported && !misaligned;
    assign reject     = cpu_req && !accept;

    // Lane selection uses the byte offset captured when the request was accepted.
    always_comb begin
        loadByte = readdata[{lane_q, 3'b000} +: 8];
        loadHalf = lane_q[1] ? readdata[31:16] : readdata[15:0];
        case (op_q)
            OP_LB:   loadResult = {{24{loadByte[7]}}, loadByte};
            OP_LBU:  loadResult = {24'h000000, loadByte};
            OP_LH:   loadResult = {{16{loadHalf[15]}}, loadHalf};
            OP_LHU:  loadResult = {16'h0000, loadHalf};
            default: loadResult = readdata;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = REQ;
            REQ:     if (!waitrequest) state_d = write_q ? IDLE : RDATA;
            RDATA:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        address_d = address_q;
        read_d    = read_q;
        write_d   = write_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        op_d      = op_q;
        lane_d    = lane_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            IDLE: begin
                err_d = reject;
                if (accept) begin
                    address_d = {cpu_addr[ADDR_W-1:2], 2'b00};
                    read_d    = !isStore;
                    write_d   = isStore;
                    op_d      = cpu_opcode;
                    lane_d    = cpu_addr[1:0];
                    case (opSize)
                        SZ_BYTE: begin
                            be_d    = 4'b0001 << cpu_addr[1:0];
                            wdata_d = {4{cpu_wdata[7:0]}};
                        end
                        SZ_HALF: begin
                            be_d    = cpu_addr[1] ? 4'b1100 : 4'b0011;
                            wdata_d = {2{cpu_wdata[15:0]}};
                        end
                        default: begin
                            be_d    = 4'b1111;
                            wdata_d = cpu_wdata;
                        end
                    endcase
                end
            end
            REQ: begin
                if (!waitrequest) begin
                    read_d  = 1'b0;
                    write_d = 1'b0;
                    done_d  = write_q;
                end
            end
            RDATA: begin
                rdata_d = loadResult;
                done_d  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            address_q <= '0;
            read_q    <= 1'b0;
            write_q   <= 1'b0;
            be_q      <= 4'b0000;
            wdata_q   <= 32'h0;
            rdata_q   <= 32'h0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            op_q      <= 6'h0;
            lane_q    <= 2'b00;
        end else begin
            address_q <= address_d;
            read_q    <= read_d;
            write_q   <= write_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            done_q    <= done_d;
            err_q     <= err_d;
            op_q      <= op_d;
            lane_q    <= lane_d;
        end
    end

    assign cpu_busy   = (state_q != IDLE);
    assign cpu_done   = done_q;
    assign cpu_rdata  = rdata_q;
    assign cpu_err    = err_q;
    assign address    = address_q;
    assign read       = read_q;
    assign write      = write_q;
    assign byteenable = be_q;
    assign writedata  = wdata_q;

endmodule
